// File: rtl/vram_oam_arbiter.sv
// Arbitrates the VRAM and OAM ports between the CPU, the PPU fetch engine and
// the built-in OAM DMA engine, and returns tagged read data one cycle later.
module vram_oam_arbiter #(
  parameter int unsigned DMA_LEN  = 160,
  parameter int unsigned OAM_SIZE = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_WDATA,
  output logic [7:0]  CPU_RDATA,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_RDATA,
  output logic [12:0] VRAM_ADDR,
  output logic        VRAM_RD,
  output logic        VRAM_WR,
  output logic [7:0]  VRAM_WDATA,
  input  logic [7:0]  VRAM_RDATA,
  output logic [7:0]  OAM_ADDR,
  output logic        OAM_RD,
  output logic        OAM_WR,
  output logic [7:0]  OAM_WDATA,
  input  logic [7:0]  OAM_RDATA,
  output logic [15:0] SYS_ADDR,
  output logic        SYS_RD,
  input  logic [7:0]  SYS_RDATA,
  output logic        DMA_ACTIVE
);

  typedef enum logic [1:0] {StIdle, StSetup, StRd, StWr} dma_state_e;
  typedef enum logic [1:0] {TagNone, TagVram, TagOam, TagBlocked} src_tag_e;

  localparam logic [7:0]  IdxLast = 8'(DMA_LEN - 1);
  localparam logic [16:0] OamBase = 17'h0FE00;
  localparam logic [16:0] OamEnd  = 17'(32'h0000FE00 + OAM_SIZE);
  localparam logic [15:0] DmaReg  = 16'hFF46;

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  src_tag_e   cpu_tag_q, cpu_tag_d;
  src_tag_e   ppu_tag_q, ppu_tag_d;

  logic dma_active, dma_rd, dma_wr;

  // Region decode
  logic cpu_in_vram, cpu_in_oam, ppu_in_vram, ppu_in_oam;
  assign cpu_in_vram = (CPU_ADDR[15:13] == 3'b100);
  assign ppu_in_vram = (PPU_ADDR[15:13] == 3'b100);
  assign cpu_in_oam  = ({1'b0, CPU_ADDR} >= OamBase) && ({1'b0, CPU_ADDR} < OamEnd);
  assign ppu_in_oam  = ({1'b0, PPU_ADDR} >= OamBase) && ({1'b0, PPU_ADDR} < OamEnd);

  // Ownership follows the current mode and DMA state with no registering
  logic ppu_owns_vram, ppu_scan_draw, ppu_owns_oam, cpu_owns_oam;
  assign ppu_owns_vram = LCD_EN && (PPU_MODE == 2'd3);
  assign ppu_scan_draw = LCD_EN && PPU_MODE[1];
  assign ppu_owns_oam  = !dma_active && ppu_scan_draw;
  assign cpu_owns_oam  = !dma_active && !ppu_scan_draw;

  logic cpu_vram_rd_gnt, cpu_vram_wr_gnt, ppu_vram_rd_gnt;
  logic cpu_oam_rd_gnt, cpu_oam_wr_gnt, ppu_oam_rd_gnt;
  logic dma_reg_wr;

  assign cpu_vram_rd_gnt = CPU_RD && cpu_in_vram && !ppu_owns_vram;
  assign cpu_vram_wr_gnt = CPU_WR && cpu_in_vram && !ppu_owns_vram;
  assign ppu_vram_rd_gnt = PPU_RD && ppu_in_vram && ppu_owns_vram;
  assign cpu_oam_rd_gnt  = CPU_RD && cpu_in_oam && cpu_owns_oam;
  assign cpu_oam_wr_gnt  = CPU_WR && cpu_in_oam && cpu_owns_oam;
  assign ppu_oam_rd_gnt  = PPU_RD && ppu_in_oam && ppu_owns_oam;
  assign dma_reg_wr      = CPU_WR && (CPU_ADDR == DmaReg);

  // DMA state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
    end
  end

  // DMA next state; an FF46 write restarts from any state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    case (state_q)
      StIdle:  ;
      StSetup: state_d = StRd;
      StRd:    state_d = StWr;
      StWr: begin
        if (idx_q == IdxLast) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          state_d = StRd;
          idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (dma_reg_wr) begin
      state_d = StSetup;
      src_d   = CPU_WDATA;
      idx_d   = '0;
    end
  end

  // DMA outputs
  always_comb begin
    dma_active = 1'b0;
    dma_rd     = 1'b0;
    dma_wr     = 1'b0;
    case (state_q)
      StIdle:  ;
      StSetup: dma_active = 1'b1;
      StRd: begin
        dma_active = 1'b1;
        dma_rd     = 1'b1;
      end
      StWr: begin
        dma_active = 1'b1;
        dma_wr     = 1'b1;
      end
      default: ;
    endcase
  end

  assign DMA_ACTIVE = dma_active;
  assign SYS_RD     = dma_rd;
  assign SYS_ADDR   = {src_q, idx_q};

  // VRAM port
  always_comb begin
    VRAM_ADDR  = ppu_owns_vram ? PPU_ADDR[12:0] : CPU_ADDR[12:0];
    VRAM_RD    = cpu_vram_rd_gnt || ppu_vram_rd_gnt;
    VRAM_WR    = cpu_vram_wr_gnt;
    VRAM_WDATA = CPU_WDATA;
  end

  // OAM port
  always_comb begin
    OAM_ADDR  = CPU_ADDR[7:0];
    OAM_RD    = cpu_oam_rd_gnt;
    OAM_WR    = cpu_oam_wr_gnt;
    OAM_WDATA = CPU_WDATA;
    if (dma_active) begin
      OAM_ADDR  = idx_q;
      OAM_RD    = 1'b0;
      OAM_WR    = dma_wr;
      OAM_WDATA = SYS_RDATA;
    end else if (ppu_owns_oam) begin
      OAM_ADDR  = PPU_ADDR[7:0];
      OAM_RD    = ppu_oam_rd_gnt;
      OAM_WR    = 1'b0;
    end
  end

  // Read-return source tags
  always_comb begin
    cpu_tag_d = TagNone;
    if (CPU_RD) begin
      if (cpu_in_vram) begin
        cpu_tag_d = cpu_vram_rd_gnt ? TagVram : TagBlocked;
      end else if (cpu_in_oam) begin
        cpu_tag_d = cpu_oam_rd_gnt ? TagOam : TagBlocked;
      end
    end
  end

  always_comb begin
    ppu_tag_d = TagNone;
    if (PPU_RD) begin
      if (ppu_in_vram) begin
        ppu_tag_d = ppu_vram_rd_gnt ? TagVram : TagBlocked;
      end else if (ppu_in_oam) begin
        ppu_tag_d = ppu_oam_rd_gnt ? TagOam : TagBlocked;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_tag_q <= TagNone;
      ppu_tag_q <= TagNone;
    end else begin
      cpu_tag_q <= cpu_tag_d;
      ppu_tag_q <= ppu_tag_d;
    end
  end

  always_comb begin
    case (cpu_tag_q)
      TagVram: CPU_RDATA = VRAM_RDATA;
      TagOam:  CPU_RDATA = OAM_RDATA;
      default: CPU_RDATA = 8'hFF;
    endcase
    case (ppu_tag_q)
      TagVram: PPU_RDATA = VRAM_RDATA;
      TagOam:  PPU_RDATA = OAM_RDATA;
      default: PPU_RDATA = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Randomized and directed bench for vram_oam_arbiter: a reference model predicts
// strobes and read data; a monitor pops predicted read data from queues.
module tb_vram_oam_arbiter;

  localparam int DmaLen = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic [15:0] CPU_ADDR;
  logic        CPU_RD, CPU_WR;
  logic [7:0]  CPU_WDATA, CPU_RDATA;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_RDATA;
  logic [12:0] VRAM_ADDR;
  logic        VRAM_RD, VRAM_WR;
  logic [7:0]  VRAM_WDATA, VRAM_RDATA;
  logic [7:0]  OAM_ADDR;
  logic        OAM_RD, OAM_WR;
  logic [7:0]  OAM_WDATA, OAM_RDATA;
  logic [15:0] SYS_ADDR;
  logic        SYS_RD;
  logic [7:0]  SYS_RDATA;
  logic        DMA_ACTIVE;

  vram_oam_arbiter #(.DMA_LEN(160), .OAM_SIZE(160)) dut (
    .clk(clk), .rst(rst), .LCD_EN(LCD_EN), .PPU_MODE(PPU_MODE),
    .CPU_ADDR(CPU_ADDR), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_WDATA(CPU_WDATA),
    .CPU_RDATA(CPU_RDATA), .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR), .PPU_RDATA(PPU_RDATA),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_RD(VRAM_RD), .VRAM_WR(VRAM_WR), .VRAM_WDATA(VRAM_WDATA),
    .VRAM_RDATA(VRAM_RDATA), .OAM_ADDR(OAM_ADDR), .OAM_RD(OAM_RD), .OAM_WR(OAM_WR),
    .OAM_WDATA(OAM_WDATA), .OAM_RDATA(OAM_RDATA), .SYS_ADDR(SYS_ADDR), .SYS_RD(SYS_RD),
    .SYS_RDATA(SYS_RDATA), .DMA_ACTIVE(DMA_ACTIVE)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sys_byte(input logic [15:0] a);
    return (a[15:8] * 8'd13) ^ a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] vram_init(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] oam_init(input int i);
    return 8'(i) ^ 8'h3C;
  endfunction

  // Synchronous RAMs with 1-cycle read latency
  logic       mem_init = 1'b0;
  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem  [256];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) vram_mem[i] <= vram_init(i);
      for (int i = 0; i < 256; i++) oam_mem[i] <= oam_init(i);
      mem_init <= 1'b1;
    end else begin
      if (VRAM_WR) vram_mem[VRAM_ADDR] <= VRAM_WDATA;
      if (VRAM_RD) VRAM_RDATA <= vram_mem[VRAM_ADDR];
      if (OAM_WR) oam_mem[OAM_ADDR] <= OAM_WDATA;
      if (OAM_RD) OAM_RDATA <= oam_mem[OAM_ADDR];
      if (SYS_RD) SYS_RDATA <= sys_byte(SYS_ADDR);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] exp_vram [8192];
  logic [7:0] exp_oam  [256];
  logic [7:0] cpu_q [$];
  logic [7:0] ppu_q [$];
  bit         dma_on;
  int         dma_t;   // 0 = setup, odd = read byte (t-1)/2, even = write byte (t-2)/2
  logic [7:0] dma_src;
  logic       last_active;

  task automatic model_cycle();
    bit cv, co, pv, po, ppu_v, ppu_o, cpu_o, d_rd, d_wr;
    bit e_vrd, e_vwr, e_ord, e_owr;
    int k;
    cv = CPU_ADDR >= 16'h8000 && CPU_ADDR <= 16'h9FFF;
    co = CPU_ADDR >= 16'hFE00 && CPU_ADDR <= 16'hFE9F;
    pv = PPU_ADDR >= 16'h8000 && PPU_ADDR <= 16'h9FFF;
    po = PPU_ADDR >= 16'hFE00 && PPU_ADDR <= 16'hFE9F;
    ppu_v = LCD_EN && PPU_MODE == 2'd3;
    ppu_o = !dma_on && LCD_EN && (PPU_MODE == 2'd2 || PPU_MODE == 2'd3);
    cpu_o = !dma_on && !(LCD_EN && (PPU_MODE == 2'd2 || PPU_MODE == 2'd3));
    d_rd = dma_on && (dma_t % 2 == 1);
    d_wr = dma_on && dma_t > 0 && (dma_t % 2 == 0);
    k = d_rd ? (dma_t - 1) / 2 : (dma_t - 2) / 2;
    e_vrd = (CPU_RD && cv && !ppu_v) || (PPU_RD && pv && ppu_v);
    e_vwr = CPU_WR && cv && !ppu_v;
    e_ord = (CPU_RD && co && cpu_o) || (PPU_RD && po && ppu_o);
    e_owr = (CPU_WR && co && cpu_o) || d_wr;
    cmp("strobes", {VRAM_RD, VRAM_WR, OAM_RD, OAM_WR, SYS_RD, DMA_ACTIVE},
        {e_vrd, e_vwr, e_ord, e_owr, d_rd, dma_on});
    if (e_vrd || e_vwr) cmp("vram_addr", VRAM_ADDR, ppu_v ? PPU_ADDR[12:0] : CPU_ADDR[12:0]);
    if (e_vwr) cmp("vram_wdata", VRAM_WDATA, CPU_WDATA);
    if (e_ord || e_owr)
      cmp("oam_addr", OAM_ADDR, d_wr ? 8'(k) : (ppu_o ? PPU_ADDR[7:0] : CPU_ADDR[7:0]));
    if (e_owr) cmp("oam_wdata", OAM_WDATA, d_wr ? sys_byte({dma_src, 8'(k)}) : CPU_WDATA);
    if (d_rd) cmp("sys_addr", SYS_ADDR, {dma_src, 8'(k)});
    if (CPU_RD)
      cpu_q.push_back(cv ? (!ppu_v ? exp_vram[CPU_ADDR[12:0]] : 8'hFF)
                         : (co && cpu_o) ? exp_oam[CPU_ADDR[7:0]] : 8'hFF);
    if (PPU_RD)
      ppu_q.push_back(pv ? (ppu_v ? exp_vram[PPU_ADDR[12:0]] : 8'hFF)
                         : (po && ppu_o) ? exp_oam[PPU_ADDR[7:0]] : 8'hFF);
    if (CPU_WR && cv && !ppu_v) exp_vram[CPU_ADDR[12:0]] = CPU_WDATA;
    if (CPU_WR && co && cpu_o) exp_oam[CPU_ADDR[7:0]] = CPU_WDATA;
    if (d_wr) exp_oam[k] = sys_byte({dma_src, 8'(k)});
    last_active = DMA_ACTIVE;
    if (dma_on) begin
      if (dma_t == 2 * DmaLen) dma_on = 0;
      else dma_t++;
    end
    if (CPU_WR && CPU_ADDR == 16'hFF46) begin
      dma_on = 1;
      dma_t = 0;
      dma_src = CPU_WDATA;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic drive(input logic lcd, input logic [1:0] mode, input logic crd, input logic cwr,
                       input logic [15:0] ca, input logic [7:0] wd, input logic prd,
                       input logic [15:0] pa);
    LCD_EN = lcd; PPU_MODE = mode; CPU_RD = crd; CPU_WR = cwr; CPU_ADDR = ca;
    CPU_WDATA = wd; PPU_RD = prd; PPU_ADDR = pa;
    #1;
    model_cycle();
    @(negedge clk);
  endtask

  task automatic idle(input logic lcd, input logic [1:0] mode);
    drive(lcd, mode, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic oam_readback();
    for (int i = 0; i < DmaLen; i++)
      drive(1'b0, 2'd0, 1'b1, 1'b0, 16'(16'hFE00 + i), 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic count_active(input string name);
    int n = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 100) drive(1'b0, 2'd0, 1'b0, 1'b1, 16'hFE00, 8'hEE, 1'b0, 16'h0000);
      else idle(1'b0, 2'd0);
      if (last_active) n++;
    end
    cmp(name, n, 321);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 16'(16'h8000 + $urandom_range(0, 16'h1FFF));
      1: return 16'(16'hFE00 + $urandom_range(0, 16'hBF));
      2: return 16'($urandom);
      default: return 16'(16'hC000 + $urandom_range(0, 16'h3FF));
    endcase
  endfunction

  // Monitor: read data is due the cycle after each read strobe
  initial begin
    logic c, p;
    forever begin
      @(posedge clk);
      c = CPU_RD && rst;
      p = PPU_RD && rst;
      #1;
      if (c) begin
        if (cpu_q.size() == 0) cmp("cpu_q_underflow", 1, 0);
        else cmp("cpu_rdata", CPU_RDATA, cpu_q.pop_front());
      end
      if (p) begin
        if (ppu_q.size() == 0) cmp("ppu_q_underflow", 1, 0);
        else cmp("ppu_rdata", PPU_RDATA, ppu_q.pop_front());
      end
    end
  end

  initial begin
    logic lcd, crd, cwr, prd;
    logic [1:0] mode;
    logic [15:0] ca;
    logic [7:0] wd;
    LCD_EN = 0; PPU_MODE = 0; CPU_RD = 0; CPU_WR = 0; CPU_ADDR = 0; CPU_WDATA = 0;
    PPU_RD = 0; PPU_ADDR = 0;
    for (int i = 0; i < 8192; i++) exp_vram[i] = vram_init(i);
    for (int i = 0; i < 256; i++) exp_oam[i] = oam_init(i);
    dma_on = 0; dma_t = 0; dma_src = 0; last_active = 0;
    repeat (3) @(negedge clk);
    cmp("rst_dma_active", DMA_ACTIVE, 0);
    cmp("rst_cpu_rdata", CPU_RDATA, 8'hFF);
    cmp("rst_ppu_rdata", PPU_RDATA, 8'hFF);
    cmp("rst_strobes", {VRAM_RD, VRAM_WR, OAM_RD, OAM_WR, SYS_RD}, 0);
    rst = 1'b1;

    // LCD off: CPU owns VRAM, PPU blocked
    drive(1'b0, 2'd0, 1'b1, 1'b0, 16'h8010, 8'h00, 1'b0, 16'h0000);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h9800);
    // DRAW: CPU VRAM write dropped, PPU read granted, CPU read blocked
    drive(1'b1, 2'd3, 1'b0, 1'b1, 16'h9800, 8'h5A, 1'b0, 16'h0000);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h9800);
    drive(1'b1, 2'd3, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 16'hFE10);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 16'h9800, 8'h00, 1'b0, 16'h0000);
    // SCAN: OAM owned by PPU; H_BLANK hands it back to the CPU
    drive(1'b1, 2'd2, 1'b1, 1'b0, 16'hFE04, 8'h00, 1'b0, 16'h0000);
    drive(1'b1, 2'd2, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'hFE04);
    drive(1'b1, 2'd2, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h8004);
    drive(1'b1, 2'd0, 1'b0, 1'b1, 16'hFE04, 8'hA7, 1'b0, 16'h0000);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 16'hFE04, 8'h00, 1'b1, 16'hFE04);
    drive(1'b1, 2'd1, 1'b1, 1'b0, 16'hFEA4, 8'h00, 1'b0, 16'h0000);

    // Full DMA from C100, with a CPU OAM write dropped mid-transfer
    drive(1'b0, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'hC1, 1'b0, 16'h0000);
    count_active("dma_len_full");
    oam_readback();

    // Restart at idx 50
    drive(1'b0, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'hC3, 1'b0, 16'h0000);
    for (int i = 0; i < 400 && dma_t != 101; i++) idle(1'b0, 2'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'hC2, 1'b0, 16'h0000);
    count_active("dma_len_restart");
    oam_readback();

    // Reset at idx 80
    drive(1'b0, 2'd0, 1'b0, 1'b1, 16'hFF46, 8'hC5, 1'b0, 16'h0000);
    for (int i = 0; i < 400 && dma_t != 161; i++) idle(1'b0, 2'd0);
    rst = 1'b0;
    #1;
    cmp("midrst_dma_active", DMA_ACTIVE, 0);
    cmp("midrst_strobes", {VRAM_RD, VRAM_WR, OAM_RD, OAM_WR, SYS_RD}, 0);
    dma_on = 0;
    dma_t = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) idle(1'b0, 2'd0);
    oam_readback();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      lcd = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      crd = 0;
      cwr = 0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: crd = 1;
        4, 5, 6: cwr = 1;
        default: ;
      endcase
      ca = rand_addr();
      wd = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        crd = 0;
        cwr = 1;
        ca = 16'hFF46;
        wd = 8'(8'hC0 + $urandom_range(0, 3));
      end
      prd = 1'($urandom_range(0, 1));
      drive(lcd, mode, crd, cwr, ca, wd, prd, rand_addr());
    end
    for (int i = 0; i < 400 && dma_on; i++) idle(1'b0, 2'd0);
    oam_readback();
    idle(1'b0, 2'd0);
    cmp("cpu_q_drained", cpu_q.size(), 0);
    cmp("ppu_q_drained", ppu_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
